// File: rtl/pipelined_decode_unit.sv
// Single-stage decode: field split, immediate generation, bypassed register file,
// busy-vector scoreboard and a registered output bundle with valid/ready handshake.
module pipelined_decode_unit #(
  parameter int          CORE         = 0,
  parameter int unsigned ADDRESS_BITS = 20,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned REG_SEL_BITS = 5
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [ADDRESS_BITS-1:0] PC,
  input  logic [31:0]             instruction,
  input  logic                    inst_valid,
  output logic                    inst_ready,
  input  logic [1:0]              extend_sel,
  input  logic                    write,
  input  logic [REG_SEL_BITS-1:0] write_reg,
  input  logic [DATA_WIDTH-1:0]   write_data,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ADDRESS_BITS-1:0] out_PC,
  output logic [6:0]              opcode,
  output logic [2:0]              funct3,
  output logic [6:0]              funct7,
  output logic [REG_SEL_BITS-1:0] rd,
  output logic [DATA_WIDTH-1:0]   rs1_data,
  output logic [DATA_WIDTH-1:0]   rs2_data,
  output logic [DATA_WIDTH-1:0]   extend_imm,
  output logic [ADDRESS_BITS-1:0] branch_target,
  output logic [ADDRESS_BITS-1:0] JAL_target,
  output logic [31:0]             stall_count,
  input  logic                    report
);

  localparam int unsigned NumRegs = 2 ** REG_SEL_BITS;

  function automatic logic writes_rd_op(input logic [6:0] op);
    case (op)
      7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
      7'b0000011, 7'b0010011, 7'b0110011: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  function automatic logic uses_rs1_op(input logic [6:0] op);
    return !(op == 7'b0110111 || op == 7'b0010111 || op == 7'b1101111);
  endfunction

  function automatic logic uses_rs2_op(input logic [6:0] op);
    return op == 7'b1100011 || op == 7'b0100011 || op == 7'b0110011;
  endfunction

  logic [DATA_WIDTH-1:0]   rf_q [NumRegs];
  logic [NumRegs-1:0]      busy_q, busy_d;
  logic                    out_valid_q, out_valid_d;
  logic                    out_wr_q;
  logic [ADDRESS_BITS-1:0] pc_q, br_q, jal_q;
  logic [6:0]              opcode_q, funct7_q;
  logic [2:0]              funct3_q;
  logic [REG_SEL_BITS-1:0] rd_q;
  logic [DATA_WIDTH-1:0]   rs1_q, rs2_q, imm_q;
  logic [31:0]             stall_q, stall_d;
  logic [31:0]             cycle_q;

  logic [6:0]              op_in;
  logic [REG_SEL_BITS-1:0] rd_in, rs1_idx, rs2_idx;
  logic [DATA_WIDTH-1:0]   rs1_val, rs2_val, imm_val;
  logic                    rs1_pend, rs2_pend, hazard, accept, handoff;
  logic signed [12:0]      sb_raw;
  logic signed [20:0]      uj_raw;

  assign op_in   = instruction[6:0];
  assign rd_in   = REG_SEL_BITS'(instruction[11:7]);
  assign rs1_idx = REG_SEL_BITS'(instruction[19:15]);
  assign rs2_idx = REG_SEL_BITS'(instruction[24:20]);
  assign sb_raw  = {instruction[31], instruction[7], instruction[30:25], instruction[11:8], 1'b0};
  assign uj_raw  = {instruction[31], instruction[19:12], instruction[20], instruction[30:21], 1'b0};

  always_comb begin
    imm_val = '0;
    unique case (extend_sel)
      2'b00: imm_val = DATA_WIDTH'($signed(instruction[31:20]));
      2'b01: imm_val = DATA_WIDTH'($signed({instruction[31:25], instruction[11:7]}));
      2'b10: imm_val = DATA_WIDTH'($signed({instruction[31:12], 12'b0}));
      2'b11: imm_val = DATA_WIDTH'(uj_raw);
    endcase
  end

  // Register reads with write-through bypass; x0 is hardwired to zero.
  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (rs1_idx != '0) rs1_val = (write && write_reg == rs1_idx) ? write_data : rf_q[rs1_idx];
    if (rs2_idx != '0) rs2_val = (write && write_reg == rs2_idx) ? write_data : rf_q[rs2_idx];
  end

  // A source is pending if the output stage will produce it, or it is busy and not being
  // written back this very cycle.
  always_comb begin
    rs1_pend = (rs1_idx != '0) &&
               ((out_valid_q && out_wr_q && rd_q == rs1_idx) ||
                (busy_q[rs1_idx] && !(write && write_reg == rs1_idx)));
    rs2_pend = (rs2_idx != '0) &&
               ((out_valid_q && out_wr_q && rd_q == rs2_idx) ||
                (busy_q[rs2_idx] && !(write && write_reg == rs2_idx)));
    hazard     = inst_valid && ((uses_rs1_op(op_in) && rs1_pend) ||
                                (uses_rs2_op(op_in) && rs2_pend));
    inst_ready = !hazard && (!out_valid_q || out_ready || flush);
    accept     = inst_valid && inst_ready;
    handoff    = out_valid_q && out_ready && !flush;
  end

  always_comb begin
    busy_d = busy_q;
    if (write) busy_d[write_reg] = 1'b0;
    if (handoff && out_wr_q) busy_d[rd_q] = 1'b1;
    busy_d[0] = 1'b0;

    out_valid_d = out_valid_q;
    if (accept)                                out_valid_d = 1'b1;
    else if (flush || (out_valid_q && out_ready)) out_valid_d = 1'b0;

    stall_d = stall_q;
    if (inst_valid && !inst_ready) stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(NumRegs); i++) rf_q[i] <= '0;
      busy_q      <= '0;
      out_valid_q <= 1'b0;
      out_wr_q    <= 1'b0;
      pc_q        <= '0;
      br_q        <= '0;
      jal_q       <= '0;
      opcode_q    <= '0;
      funct3_q    <= '0;
      funct7_q    <= '0;
      rd_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      imm_q       <= '0;
      stall_q     <= '0;
      cycle_q     <= '0;
    end else begin
      if (write && write_reg != '0) rf_q[write_reg] <= write_data;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      stall_q     <= stall_d;
      cycle_q     <= cycle_q + 32'd1;
      if (accept) begin
        out_wr_q <= writes_rd_op(op_in) && (rd_in != '0);
        pc_q     <= PC;
        br_q     <= PC + ADDRESS_BITS'(sb_raw);
        jal_q    <= PC + ADDRESS_BITS'(uj_raw);
        opcode_q <= op_in;
        funct3_q <= instruction[14:12];
        funct7_q <= instruction[31:25];
        rd_q     <= rd_in;
        rs1_q    <= rs1_val;
        rs2_q    <= rs2_val;
        imm_q    <= imm_val;
      end
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clock) begin
    if (report) begin
      $display("core %0d cycle %0d pc %h inst %h rs1 x%0d=%h rs2 x%0d=%h rd x%0d br %h jal %h imm %h busy %b",
               CORE, cycle_q, PC, instruction, rs1_idx, rs1_val, rs2_idx, rs2_val, rd_q,
               br_q, jal_q, imm_q, busy_q);
    end
  end
`endif

  assign out_valid     = out_valid_q;
  assign out_PC        = pc_q;
  assign opcode        = opcode_q;
  assign funct3        = funct3_q;
  assign funct7        = funct7_q;
  assign rd            = rd_q;
  assign rs1_data      = rs1_q;
  assign rs2_data      = rs2_q;
  assign extend_imm    = imm_q;
  assign branch_target = br_q;
  assign JAL_target    = jal_q;
  assign stall_count   = stall_q;

endmodule

// File: tb/tb_pipelined_decode_unit.sv
// Directed scenarios plus randomized traffic, checked every cycle against a
// behavioural model of the decode stage kept in the bench.
module tb_pipelined_decode_unit;

  logic        clock = 1'b0;
  logic        reset, inst_valid, write, flush, out_ready, report;
  logic [19:0] PC;
  logic [31:0] instruction, write_data;
  logic [1:0]  extend_sel;
  logic [4:0]  write_reg;
  logic        inst_ready, out_valid;
  logic [19:0] out_PC, branch_target, JAL_target;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic [31:0] rs1_data, rs2_data, extend_imm, stall_count;

  int n_vec = 0;
  int n_err = 0;

  pipelined_decode_unit dut (
    .clock(clock), .reset(reset), .PC(PC), .instruction(instruction),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .extend_sel(extend_sel),
    .write(write), .write_reg(write_reg), .write_data(write_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_PC(out_PC), .opcode(opcode),
    .funct3(funct3), .funct7(funct7), .rd(rd), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .extend_imm(extend_imm), .branch_target(branch_target), .JAL_target(JAL_target),
    .stall_count(stall_count), .report(report)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  // Reference model state
  logic [31:0] m_regs [32];
  bit          m_busy [32];
  bit          m_ov, m_wr;
  logic [19:0] m_pc, m_bt, m_jt;
  logic [6:0]  m_op, m_f7;
  logic [2:0]  m_f3;
  logic [4:0]  m_rd;
  logic [31:0] m_r1, m_r2, m_imm, m_stall;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 0;
    end
    m_ov = 0; m_wr = 0; m_pc = '0; m_bt = '0; m_jt = '0; m_op = '0; m_f7 = '0;
    m_f3 = '0; m_rd = '0; m_r1 = '0; m_r2 = '0; m_imm = '0; m_stall = '0;
  endtask

  function automatic bit writes_rd(input logic [6:0] op, input logic [4:0] r);
    return (op inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h33}) && r != 0;
  endfunction

  function automatic bit uses_rs1(input logic [6:0] op);
    return !(op inside {7'h37, 7'h17, 7'h6F});
  endfunction

  function automatic bit uses_rs2(input logic [6:0] op);
    return op inside {7'h63, 7'h23, 7'h33};
  endfunction

  function automatic bit pending(input int r);
    bit in_out, wb;
    if (r == 0) return 0;
    in_out = m_ov && m_wr && (m_rd == r);
    wb     = write && (write_reg == r);
    return in_out || (m_busy[r] && !wb);
  endfunction

  function automatic logic [31:0] read_reg(input int r);
    if (r == 0) return '0;
    if (write && write_reg == r) return write_data;
    return m_regs[r];
  endfunction

  function automatic logic [31:0] uj_imm(input logic [31:0] ins);
    int s, sgn;
    s = $signed(ins);
    sgn = s >>> 31;
    return (sgn << 20) | int'(((ins >> 21) & 32'h3ff) << 1) | int'(((ins >> 20) & 1) << 11) |
           int'(((ins >> 12) & 32'hff) << 12);
  endfunction

  function automatic logic [31:0] sb_imm(input logic [31:0] ins);
    int s, sgn;
    s = $signed(ins);
    sgn = s >>> 31;
    return (sgn << 12) | int'(((ins >> 8) & 15) << 1) | int'(((ins >> 25) & 63) << 5) |
           int'(((ins >> 7) & 1) << 11);
  endfunction

  function automatic logic [31:0] ref_imm(input logic [31:0] ins, input logic [1:0] sel);
    int s, hi;
    s = $signed(ins);
    case (sel)
      2'd0: return s >>> 20;
      2'd1: begin
        hi = s >>> 25;
        return (hi << 5) | int'((ins >> 7) & 32'h1f);
      end
      2'd2: return ins & 32'hFFFFF000;
      default: return uj_imm(ins);
    endcase
  endfunction

  function automatic logic [19:0] target(input logic [19:0] pc, input logic [31:0] imm);
    return 20'((32'(pc) + imm) % 32'h100000);
  endfunction

  // One clock cycle: check outputs against the model, then advance the model.
  task automatic tick();
    logic [6:0]  op;
    int          a, b;
    bit          hz, rdy, acc, hand;
    logic [31:0] v1, v2;
    #1;
    op = instruction[6:0];
    a  = int'(instruction[19:15]);
    b  = int'(instruction[24:20]);
    hz  = inst_valid && ((uses_rs1(op) && pending(a)) || (uses_rs2(op) && pending(b)));
    rdy = !hz && (!m_ov || out_ready || flush);
    check_eq("inst_ready", inst_ready, rdy);
    check_eq("out_valid", out_valid, m_ov);
    check_eq("out_PC", out_PC, m_pc);
    check_eq("opcode", opcode, m_op);
    check_eq("funct3", funct3, m_f3);
    check_eq("funct7", funct7, m_f7);
    check_eq("rd", rd, m_rd);
    check_eq("rs1_data", rs1_data, m_r1);
    check_eq("rs2_data", rs2_data, m_r2);
    check_eq("extend_imm", extend_imm, m_imm);
    check_eq("branch_target", branch_target, m_bt);
    check_eq("JAL_target", JAL_target, m_jt);
    check_eq("stall_count", stall_count, m_stall);
    acc  = inst_valid && rdy;
    hand = m_ov && out_ready && !flush;
    v1 = read_reg(a);
    v2 = read_reg(b);
    @(posedge clock);
    if (reset) begin
      model_reset();
    end else begin
      if (inst_valid && !rdy) m_stall = m_stall + 1;
      if (write) m_busy[write_reg] = 0;
      if (hand && m_wr) m_busy[m_rd] = 1;
      m_busy[0] = 0;
      if (write && write_reg != 0) m_regs[write_reg] = write_data;
      if (acc) begin
        m_wr  = writes_rd(op, instruction[11:7]);
        m_pc  = PC;
        m_op  = op;
        m_f3  = instruction[14:12];
        m_f7  = instruction[31:25];
        m_rd  = instruction[11:7];
        m_r1  = v1;
        m_r2  = v2;
        m_imm = ref_imm(instruction, extend_sel);
        m_bt  = target(PC, sb_imm(instruction));
        m_jt  = target(PC, uj_imm(instruction));
      end
      m_ov = acc ? 1'b1 : ((flush || (m_ov && out_ready)) ? 1'b0 : m_ov);
    end
    @(negedge clock);
  endtask

  task automatic present(input logic [31:0] ins, input logic [19:0] pc, input logic [1:0] sel);
    inst_valid  = 1'b1;
    instruction = ins;
    PC          = pc;
    extend_sel  = sel;
  endtask

  logic [6:0] ops [9] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h33, 7'h63, 7'h23};

  initial begin
    logic [31:0] ins;
    reset = 1'b1; inst_valid = 1'b0; write = 1'b0; flush = 1'b0; out_ready = 1'b0;
    report = 1'b0; PC = '0; instruction = '0; write_data = '0; extend_sel = '0; write_reg = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    model_reset();
    reset = 1'b0;
    #1;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_stall", stall_count, 0);
    check_eq("rst_inst_ready", inst_ready, 1);

    // addi x1,x0,5
    out_ready = 1'b1;
    report    = 1'b1;
    present(32'h00500093, 20'h00100, 2'd0);
    tick();
    report = 1'b0;
    check_eq("addi_valid", out_valid, 1);
    check_eq("addi_rd", rd, 1);
    check_eq("addi_imm", extend_imm, 5);
    check_eq("addi_pc", out_PC, 20'h00100);

    // add x2,x1,x1 stalls until x1 is written back
    present(32'h00108133, 20'h00104, 2'd0);
    #1 check_eq("raw_out_stall", inst_ready, 0);
    tick();
    #1 check_eq("raw_busy_stall", inst_ready, 0);
    tick();
    check_eq("raw_stall_count", stall_count, 2);
    write = 1'b1; write_reg = 5'd1; write_data = 32'd5;
    #1 check_eq("raw_wb_ready", inst_ready, 1);
    tick();
    write = 1'b0;
    check_eq("raw_rs1", rs1_data, 5);
    check_eq("raw_rs2", rs2_data, 5);

    // back-pressure for three cycles
    out_ready = 1'b0;
    present(32'h00900293, 20'h00108, 2'd0);
    for (int i = 0; i < 3; i++) begin
      #1 check_eq("bp_ready", inst_ready, 0);
      tick();
      check_eq("bp_hold_pc", out_PC, 20'h00104);
    end
    out_ready = 1'b1;
    tick();
    check_eq("bp_next_pc", out_PC, 20'h00108);

    // flush the addi x3 bundle, then add x4,x3,x3 must not stall
    present(32'h00100193, 20'h0010C, 2'd0);
    tick();
    inst_valid = 1'b0;
    flush      = 1'b1;
    tick();
    flush = 1'b0;
    check_eq("flush_valid", out_valid, 0);
    present(32'h00318233, 20'h00110, 2'd0);
    #1 check_eq("flush_no_stall", inst_ready, 1);
    tick();

    // reset with a valid bundle and busy x5
    inst_valid = 1'b0;
    reset      = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("mid_rst_valid", out_valid, 0);
    check_eq("mid_rst_stall", stall_count, 0);
    present(32'h00528333, 20'h00114, 2'd0);
    #1 check_eq("mid_rst_ready", inst_ready, 1);
    tick();
    check_eq("mid_rst_rf", rs1_data, 0);

    // jal x1,+0x20 at the top of the address space wraps
    present(32'h020000EF, 20'hFFFF0, 2'd3);
    tick();
    check_eq("jal_target", JAL_target, 20'h00010);
    check_eq("jal_imm", extend_imm, 32'h20);

    // writes to x0 are ignored
    write = 1'b1; write_reg = 5'd0; write_data = 32'd7;
    present(32'h000003B3, 20'h00000, 2'd0);
    tick();
    write = 1'b0;
    tick();
    check_eq("x0_rs1", rs1_data, 0);
    check_eq("x0_rs2", rs2_data, 0);

    for (int n = 0; n < 800; n++) begin
      ins        = $urandom;
      ins[6:0]   = ops[$urandom_range(0, 8)];
      ins[11:7]  = 5'($urandom_range(0, 3));
      ins[19:15] = 5'($urandom_range(0, 3));
      ins[24:20] = 5'($urandom_range(0, 3));
      reset      = ($urandom_range(0, 63) == 0);
      inst_valid = ($urandom_range(0, 3) != 0);
      instruction = ins;
      PC         = 20'($urandom);
      extend_sel = 2'($urandom);
      write      = ($urandom_range(0, 3) == 0);
      write_reg  = 5'($urandom_range(0, 3));
      write_data = $urandom;
      flush      = ($urandom_range(0, 7) == 0);
      out_ready  = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
